// File: rtl/gcm_input_packer.sv
// Packs a tagged 32-bit AAD/plaintext word stream into 128-bit big-endian GCM blocks
// and accumulates the len(A)||len(C) word for each message.
//
// state | meaning
// ACC   | accepting words, staging them into the current block
// LEN   | one-cycle gap after the message's final word; length word published
module gcm_input_packer #(
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [0:31]    i_word,
  input  logic           i_is_aad,
  input  logic           i_seg_last,
  input  logic           i_msg_last,
  input  logic [2:0]     i_nbytes,
  output logic           o_signal,
  output logic [0:127]   o_plain_text,
  output logic [0:127]   o_aad,
  output logic           o_is_aad,
  output logic           o_last,
  output logic [0:127]   o_instance_size
);

  typedef enum logic {ACC, LEN} state_t;

  state_t             state;
  logic               ready_q;
  logic [0:127]       stage_data;
  logic [1:0]         idx;
  logic               stage_aad;
  logic               pend;
  logic [0:127]       pend_data;
  logic               pend_aad;
  logic               pend_last;
  logic [LEN_W-1:0]   aad_bits;
  logic [LEN_W-1:0]   pt_bits;

  logic               accept;
  logic [2:0]         eff_nb;
  logic [0:31]        word_m;
  logic               type_sw;
  logic [1:0]         ins_idx;
  logic [0:127]       blk_fill;
  logic               blk_done;
  logic               msg_end;
  logic [5:0]         add_bits;
  logic [LEN_W-1:0]   aad_nx;
  logic [LEN_W-1:0]   pt_nx;
  logic [63:0]        aad_ext;
  logic [63:0]        pt_ext;

  logic               emit_v;
  logic [0:127]       emit_data;
  logic               emit_aad;
  logic               emit_last;

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                               input logic [5:0] b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + (LEN_W+1)'(b);
    return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
  endfunction

  assign o_ready  = ready_q;
  assign accept   = i_valid && ready_q;
  assign eff_nb   = (!i_seg_last || i_nbytes == 3'd0 || i_nbytes > 3'd4) ? 3'd4 : i_nbytes;
  assign add_bits = {eff_nb, 3'b000};
  assign msg_end  = i_seg_last && i_msg_last;

  // A staged partial block of the other type means the segment ended without seg_last.
  assign type_sw  = (idx != 2'd0) && (i_is_aad != stage_aad);
  assign ins_idx  = type_sw ? 2'd0 : idx;
  assign blk_done = (ins_idx == 2'd3) || i_seg_last;

  always_comb begin
    word_m = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < eff_nb) word_m[8*b +: 8] = i_word[8*b +: 8];
    end
  end

  always_comb begin
    blk_fill = type_sw ? '0 : stage_data;
    blk_fill[{ins_idx, 5'b00000} +: 32] = word_m;
  end

  assign aad_nx  = (accept && i_is_aad)  ? sat_add(aad_bits, add_bits) : aad_bits;
  assign pt_nx   = (accept && !i_is_aad) ? sat_add(pt_bits, add_bits)  : pt_bits;
  assign aad_ext = 64'(aad_nx);
  assign pt_ext  = 64'(pt_nx);

  always_comb begin
    emit_v    = 1'b0;
    emit_data = '0;
    emit_aad  = 1'b0;
    emit_last = 1'b0;
    if (accept) begin
      if (type_sw) begin
        emit_v    = 1'b1;
        emit_data = stage_data;
        emit_aad  = stage_aad;
      end else if (blk_done) begin
        emit_v    = 1'b1;
        emit_data = blk_fill;
        emit_aad  = i_is_aad;
        emit_last = msg_end;
      end
    end else if (pend) begin
      emit_v    = 1'b1;
      emit_data = pend_data;
      emit_aad  = pend_aad;
      emit_last = pend_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ACC;
      ready_q         <= 1'b1;
      stage_data      <= '0;
      idx             <= 2'd0;
      stage_aad       <= 1'b0;
      pend            <= 1'b0;
      pend_data       <= '0;
      pend_aad        <= 1'b0;
      pend_last       <= 1'b0;
      aad_bits        <= '0;
      pt_bits         <= '0;
      o_signal        <= 1'b0;
      o_plain_text    <= '0;
      o_aad           <= '0;
      o_is_aad        <= 1'b0;
      o_last          <= 1'b0;
      o_instance_size <= '0;
    end else begin
      o_signal <= emit_v;
      o_last   <= emit_v && emit_last;
      if (emit_v) begin
        o_is_aad <= emit_aad;
        if (emit_aad) o_aad        <= emit_data;
        else          o_plain_text <= emit_data;
      end
      if (pend && !accept) pend <= 1'b0;

      case (state)
        ACC: begin
          if (accept) begin
            aad_bits <= aad_nx;
            pt_bits  <= pt_nx;
            if (type_sw && blk_done) begin
              // Flushed block goes out now; the new single-word block follows next cycle.
              pend       <= 1'b1;
              pend_data  <= blk_fill;
              pend_aad   <= i_is_aad;
              pend_last  <= msg_end;
              stage_data <= '0;
              idx        <= 2'd0;
            end else if (type_sw) begin
              stage_data <= blk_fill;
              idx        <= 2'd1;
              stage_aad  <= i_is_aad;
            end else if (blk_done) begin
              stage_data <= '0;
              idx        <= 2'd0;
            end else begin
              stage_data <= blk_fill;
              idx        <= idx + 2'd1;
              stage_aad  <= i_is_aad;
            end
            if (msg_end) begin
              state           <= LEN;
              o_instance_size <= {aad_ext, pt_ext};
              aad_bits        <= '0;
              pt_bits         <= '0;
            end
            ready_q <= !(msg_end || (type_sw && blk_done));
          end else begin
            ready_q <= 1'b1;
          end
        end
        LEN: begin
          state   <= ACC;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ACC;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_input_packer.sv
// Directed bench for gcm_input_packer: expected blocks are queued as words are driven
// and checked against each strobe by a negedge monitor.
module tb_gcm_input_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [0:31]  i_word = '0;
  logic         i_is_aad = 1'b0;
  logic         i_seg_last = 1'b0;
  logic         i_msg_last = 1'b0;
  logic [2:0]   i_nbytes = 3'd4;
  logic         o_signal;
  logic [0:127] o_plain_text;
  logic [0:127] o_aad;
  logic         o_is_aad;
  logic         o_last;
  logic [0:127] o_instance_size;

  gcm_input_packer #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .i_is_aad(i_is_aad), .i_seg_last(i_seg_last),
    .i_msg_last(i_msg_last), .i_nbytes(i_nbytes), .o_signal(o_signal),
    .o_plain_text(o_plain_text), .o_aad(o_aad), .o_is_aad(o_is_aad),
    .o_last(o_last), .o_instance_size(o_instance_size)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         aad;
    logic [127:0] data;
    logic         last;
    logic [127:0] isize;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   last_acc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_signal === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("extra_strobe", o_signal, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("blk_type", o_is_aad, e.aad);
        chk("blk_data", e.aad ? o_aad : o_plain_text, e.data);
        chk("blk_last", o_last, e.last);
        chk("blk_cycle", cyc, e.cyc);
        if (e.last) chk("inst_size", o_instance_size, e.isize);
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic aad, input logic sl,
                      input logic ml, input logic [2:0] nb, output int stall);
    i_valid = 1'b1; i_word = w; i_is_aad = aad;
    i_seg_last = sl; i_msg_last = ml; i_nbytes = nb;
    stall = 0;
    while (o_ready !== 1'b1 && stall < 20) begin
      @(posedge clk); #1;
      stall++;
    end
    if (o_ready !== 1'b1) chk("ready_timeout", o_ready, 1);
    @(posedge clk); #1;
    last_acc = cyc;
    i_valid = 1'b0; i_seg_last = 1'b0; i_msg_last = 1'b0;
  endtask

  task automatic expb(input logic aad, input logic [127:0] d, input logic last,
                      input logic [127:0] isz);
    exp_t e;
    e = '{aad: aad, data: d, last: last, isize: isz, cyc: last_acc};
    sbq.push_back(e);
  endtask

  task automatic len_check();
    chk("len_ready_low", o_ready, 0);
    @(posedge clk); #1;
    chk("len_ready_high", o_ready, 1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_signal", o_signal, 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] w [0:11];

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready_init", o_ready, 1);
    chk("rst_signal_init", o_signal, 0);
    chk("rst_isize_init", o_instance_size, 0);
    chk("rst_pt_init", o_plain_text, 0);
    chk("rst_aad_init", o_aad, 0);

    // Reset mid-block discards the staged AAD words.
    send(32'hAAAA0001, 1, 0, 0, 4, st);
    send(32'hAAAA0002, 1, 0, 0, 4, st);
    pulse_reset();
    chk("rst_isize_mid", o_instance_size, 0);
    send(32'h00112233, 0, 0, 0, 4, st);
    send(32'h44556677, 0, 0, 0, 4, st);
    send(32'h8899AABB, 0, 0, 0, 4, st);
    send(32'hCCDDEEFF, 0, 1, 1, 4, st);
    expb(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1, {64'd0, 64'd128});
    len_check();

    // AAD with partial final word, then two plaintext blocks.
    send(32'h01020304, 1, 0, 0, 4, st);
    send(32'h05060708, 1, 0, 0, 4, st);
    send(32'h090A0B0C, 1, 0, 0, 4, st);
    send(32'h0D0E0F10, 1, 0, 0, 4, st);
    expb(1, 128'h01020304_05060708_090A0B0C_0D0E0F10, 0, 0);
    send(32'hDEADBEEF, 1, 1, 0, 2, st);
    expb(1, {32'hDEAD0000, 96'd0}, 0, 0);
    for (int i = 0; i < 8; i++) w[i] = 32'hA0000000 + i;
    for (int i = 0; i < 8; i++) begin
      send(w[i], 0, (i == 7), (i == 7), 4, st);
      if (i == 3) expb(0, {w[0], w[1], w[2], w[3]}, 0, 0);
      if (i == 7) expb(0, {w[4], w[5], w[6], w[7]}, 1, {64'd144, 64'd256});
    end
    len_check();

    // Partial plaintext: one byte kept from the final word.
    send(32'h11111111, 0, 0, 0, 4, st);
    send(32'h22222222, 0, 0, 0, 4, st);
    send(32'hA1B2C3D4, 0, 1, 1, 1, st);
    expb(0, {32'h11111111, 32'h22222222, 32'hA1000000, 32'h0}, 1, {64'd0, 64'd72});
    len_check();
    chk("aad_hold", o_aad, {32'hDEAD0000, 96'd0});

    // Streaming 12 words; a stray msg_last without seg_last must be ignored.
    for (int i = 0; i < 12; i++) w[i] = 32'h10000000 + i;
    for (int i = 0; i < 12; i++) begin
      send(w[i], 0, (i == 11), (i == 4 || i == 11), 4, st);
      chk("stream_stall", st, 0);
      if (i == 3)  expb(0, {w[0], w[1], w[2], w[3]}, 0, 0);
      if (i == 7)  expb(0, {w[4], w[5], w[6], w[7]}, 0, 0);
      if (i == 11) expb(0, {w[8], w[9], w[10], w[11]}, 1, {64'd0, 64'd384});
      if (i < 11)  chk("stream_ready", o_ready, 1);
    end
    len_check();

    // AAD-only message after a fresh reset.
    pulse_reset();
    chk("aadonly_pt_zero", o_plain_text, 0);
    send(32'h55667788, 1, 0, 0, 4, st);
    send(32'h99AABBCC, 1, 1, 1, 4, st);
    expb(1, {32'h55667788, 32'h99AABBCC, 64'd0}, 1, {64'd64, 64'd0});
    len_check();
    repeat (2) @(posedge clk);
    #1 chk("aadonly_pt_hold", o_plain_text, 0);

    // Type switch without seg_last flushes the AAD block.
    send(32'hCAFE0001, 1, 0, 0, 4, st);
    send(32'hCAFE0002, 1, 0, 0, 4, st);
    send(32'hBEEF0001, 0, 0, 0, 4, st);
    expb(1, {32'hCAFE0001, 32'hCAFE0002, 64'd0}, 0, 0);
    send(32'hBEEF0002, 0, 1, 1, 4, st);
    expb(0, {32'hBEEF0001, 32'hBEEF0002, 64'd0}, 1, {64'd64, 64'd64});
    len_check();

    // nbytes of 0 and of 7 both mean a full word.
    send(32'h76543210, 0, 1, 1, 0, st);
    expb(0, {32'h76543210, 96'd0}, 1, {64'd0, 64'd32});
    len_check();
    send(32'hFEDCBA98, 1, 1, 1, 7, st);
    expb(1, {32'hFEDCBA98, 96'd0}, 1, {64'd32, 64'd0});
    len_check();

    repeat (5) @(posedge clk);
    #1 chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
